// File: rtl/mux_sel_pkg.sv
// Shared constants for the round-robin mux-select arbiter: state encoding,
// source indices and a one-hot helper.
package mux_sel_pkg;

    localparam int N_SRC = 4;

    typedef logic [1:0] src_idx_t;

    localparam src_idx_t SRC_A = 2'd0;
    localparam src_idx_t SRC_B = 2'd1;
    localparam src_idx_t SRC_C = 2'd2;
    localparam src_idx_t SRC_D = 2'd3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    function automatic logic [N_SRC-1:0] src_onehot(input src_idx_t idx);
        logic [N_SRC-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin pick over four requesters; the search starts just
// after `last`, so the previous winner is always the lowest priority.
module rr_pick4
    import mux_sel_pkg::*;
(
    input  logic [N_SRC-1:0] req,
    input  src_idx_t         last,
    output src_idx_t         winner,
    output logic             any
);

    always_comb begin
        src_idx_t idx;
        winner = last;
        any    = 1'b0;
        idx    = last;
        for (int i = 1; i <= N_SRC; i++) begin
            idx = last + src_idx_t'(i);
            if (!any && req[idx]) begin
                winner = idx;
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_mux_sel_arbiter.sv
// Round-robin arbiter driving the registered select and one-hot grant of a
// 4:1 mux tree; tenures end on done, request drop or hold-limit expiry.
module rr_mux_sel_arbiter
    import mux_sel_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SRC-1:0] req,
    input  logic             done,
    output logic [1:0]       sel,
    output logic [N_SRC-1:0] gnt,
    output logic             gnt_valid
);

    arb_state_e        state_q, state_d;
    src_idx_t          sel_q, sel_d;
    src_idx_t          last_q, last_d;
    logic [N_SRC-1:0]  gnt_q, gnt_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    src_idx_t pick_winner;
    logic     pick_any;
    logic     hold_at_max;
    logic     rel;
    logic     load;

    rr_pick4 u_pick (
        .req    (req),
        .last   (last_q),
        .winner (pick_winner),
        .any    (pick_any)
    );

    assign hold_at_max = (hold_q == HOLD_W'(MAX_HOLD));
    // Any of the three end-of-tenure causes collapses into one release.
    assign rel = done | ~req[sel_q] | hold_at_max;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        hold_d  = hold_q;
        load    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    load = 1'b1;
                end
            end
            ST_GRANT: begin
                if (rel) begin
                    if (pick_any) begin
                        load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                        hold_d  = '0;
                    end
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                hold_d  = '0;
            end
        endcase

        if (load) begin
            state_d = ST_GRANT;
            sel_d   = pick_winner;
            gnt_d   = src_onehot(pick_winner);
            last_d  = pick_winner;
            hold_d  = HOLD_W'(1);
        end
    end

    // last resets to SRC_D so the first search after reset begins at SRC_A.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= SRC_A;
            gnt_q   <= '0;
            last_q  <= SRC_D;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

    assign sel       = sel_q;
    assign gnt       = gnt_q;
    assign gnt_valid = (state_q == ST_GRANT);

    a_valid_matches_gnt: assert property (
        @(posedge clk) disable iff (!rst_n) gnt_valid == (|gnt_q));
    a_gnt_onehot: assert property (
        @(posedge clk) disable iff (!rst_n) $onehot0(gnt_q));
    a_hold_bounded: assert property (
        @(posedge clk) disable iff (!rst_n) hold_q <= HOLD_W'(MAX_HOLD));
    a_sel_stable_idle: assert property (
        @(posedge clk) disable iff (!rst_n) !gnt_valid |=> (!gnt_valid -> $stable(sel_q)));

endmodule

// File: tb/tb_rr_mux_sel_arbiter.sv
// Scoreboard bench for rr_mux_sel_arbiter: stimulus pushes hand-computed
// expectations, a monitor pops and compares one per clock.
module tb_rr_mux_sel_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [1:0] sel;
    logic [3:0] gnt;
    logic       gnt_valid;

    always #5 clk = ~clk;

    rr_mux_sel_arbiter #(.MAX_HOLD(8), .HOLD_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .sel       (sel),
        .gnt       (gnt),
        .gnt_valid (gnt_valid)
    );

    typedef struct {
        logic [1:0] sel;
        logic [3:0] gnt;
        logic       v;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [1:0] es,
                         input logic [3:0] eg, input logic ev);
        n_tests++;
        if (sel !== es || gnt !== eg || gnt_valid !== ev) begin
            n_fail++;
            $display("FAIL %s @%0t: got sel=%0d gnt=%b valid=%b, want sel=%0d gnt=%b valid=%b",
                     tag, $time, sel, gnt, gnt_valid, es, eg, ev);
        end
    endtask

    // Drive one cycle of inputs; the expectation is the output after the next edge.
    task automatic step(input logic [3:0] r, input logic d, input logic [1:0] es,
                        input logic [3:0] eg, input logic ev, input string tag);
        exp_t e;
        @(negedge clk);
        req  = r;
        done = d;
        e.sel = es;
        e.gnt = eg;
        e.v   = ev;
        e.tag = tag;
        sb.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check(e.tag, e.sel, e.gnt, e.v);
            end
        end
    end

    initial begin
        logic [1:0] rs;
        logic [3:0] roh;

        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 1'b0;
        #2;
        check("reset_init", 2'd0, 4'b0000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // First grant from reset: search begins at source 0, only c requests.
        step(4'b0100, 1'b0, 2'd2, 4'b0100, 1'b1, "first_grant_c");
        step(4'b0100, 1'b0, 2'd2, 4'b0100, 1'b1, "hold_c");

        // Asynchronous reset in the middle of a tenure.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("reset_mid", 2'd0, 4'b0000, 1'b0);
        @(negedge clk);
        req   = 4'b0000;
        rst_n = 1'b1;

        // All four request, no done: 0,1,2,3,0 each held 8 cycles, no gaps.
        for (int k = 0; k < 40; k++) begin
            rs  = 2'((k / 8) % 4);
            roh = 4'b0001 << rs;
            step(4'b1111, 1'b0, rs, roh, 1'b1, "rotate_all");
        end

        // Everyone drops: idle, sel keeps 0.
        step(4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, "drop_to_idle");

        // Grant b; non-granted bits wiggle; done in its 3rd cycle with req=1011.
        step(4'b0010, 1'b0, 2'd1, 4'b0010, 1'b1, "grant_b");
        step(4'b0110, 1'b0, 2'd1, 4'b0010, 1'b1, "b_other_bits");
        step(4'b0011, 1'b0, 2'd1, 4'b0010, 1'b1, "b_cycle3");
        step(4'b1011, 1'b1, 2'd3, 4'b1000, 1'b1, "done_to_d");
        step(4'b0000, 1'b0, 2'd3, 4'b0000, 1'b0, "d_drop_idle");

        // Grant c, drop it; done while idle is ignored; sole c re-granted.
        step(4'b0100, 1'b0, 2'd2, 4'b0100, 1'b1, "grant_c");
        step(4'b0000, 1'b0, 2'd2, 4'b0000, 1'b0, "c_drop_idle");
        step(4'b0000, 1'b1, 2'd2, 4'b0000, 1'b0, "done_idle");
        step(4'b0100, 1'b0, 2'd2, 4'b0100, 1'b1, "regrant_c");
        step(4'b0100, 1'b0, 2'd2, 4'b0100, 1'b1, "regrant_c_hold");
        step(4'b0000, 1'b0, 2'd2, 4'b0000, 1'b0, "c_drop_again");

        // Sole requester a for 20 cycles: continuous grant across hold expiry.
        for (int k = 0; k < 20; k++)
            step(4'b0001, 1'b0, 2'd0, 4'b0001, 1'b1, "sole_a");
        step(4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, "a_drop_idle");

        // b runs to the hold limit, then done + limit + req drop in one cycle.
        for (int k = 0; k < 8; k++)
            step(4'b0011, 1'b0, 2'd1, 4'b0010, 1'b1, "b_to_limit");
        step(4'b0101, 1'b1, 2'd2, 4'b0100, 1'b1, "triple_release");
        step(4'b0101, 1'b0, 2'd2, 4'b0100, 1'b1, "single_change");
        step(4'b0000, 1'b0, 2'd2, 4'b0000, 1'b0, "final_idle");

        for (int i = 0; i < 10 && sb.size() > 0; i++)
            @(posedge clk);
        #2;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
